// File: rtl/axi4_lite_arbiter.sv
// Two-master, one-slave AXI4-Lite arbiter with round-robin grant of one whole
// transaction (AR+R or AW+W+B) at a time; forwarding inside a grant is combinational.
module axi4_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_W-1:0]     m0_ARADDR,
    input  logic                  m0_ARVALID,
    output logic                  m0_ARREADY,
    output logic [DATA_W-1:0]     m0_RDATA,
    output logic [1:0]            m0_RRESP,
    output logic                  m0_RVALID,
    input  logic                  m0_RREADY,
    input  logic [ADDR_W-1:0]     m0_AWADDR,
    input  logic                  m0_AWVALID,
    output logic                  m0_AWREADY,
    input  logic [DATA_W-1:0]     m0_WDATA,
    input  logic [DATA_W/8-1:0]   m0_WSTRB,
    input  logic                  m0_WVALID,
    output logic                  m0_WREADY,
    output logic [1:0]            m0_BRESP,
    output logic                  m0_BVALID,
    input  logic                  m0_BREADY,

    input  logic [ADDR_W-1:0]     m1_ARADDR,
    input  logic                  m1_ARVALID,
    output logic                  m1_ARREADY,
    output logic [DATA_W-1:0]     m1_RDATA,
    output logic [1:0]            m1_RRESP,
    output logic                  m1_RVALID,
    input  logic                  m1_RREADY,
    input  logic [ADDR_W-1:0]     m1_AWADDR,
    input  logic                  m1_AWVALID,
    output logic                  m1_AWREADY,
    input  logic [DATA_W-1:0]     m1_WDATA,
    input  logic [DATA_W/8-1:0]   m1_WSTRB,
    input  logic                  m1_WVALID,
    output logic                  m1_WREADY,
    output logic [1:0]            m1_BRESP,
    output logic                  m1_BVALID,
    input  logic                  m1_BREADY,

    output logic [ADDR_W-1:0]     s_ARADDR,
    output logic                  s_ARVALID,
    input  logic                  s_ARREADY,
    input  logic [DATA_W-1:0]     s_RDATA,
    input  logic [1:0]            s_RRESP,
    input  logic                  s_RVALID,
    output logic                  s_RREADY,
    output logic [ADDR_W-1:0]     s_AWADDR,
    output logic                  s_AWVALID,
    input  logic                  s_AWREADY,
    output logic [DATA_W-1:0]     s_WDATA,
    output logic [DATA_W/8-1:0]   s_WSTRB,
    output logic                  s_WVALID,
    input  logic                  s_WREADY,
    input  logic [1:0]            s_BRESP,
    input  logic                  s_BVALID,
    output logic                  s_BREADY,

    output logic                  busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0] state;
    logic       owner;
    logic       last;

    logic req_rd0, req_rd1, req_wr0, req_wr1;
    logic any0, any1;
    logic winner, winner_rd;
    logic rd_gnt, wr_gnt;

    assign req_rd0 = m0_ARVALID;
    assign req_rd1 = m1_ARVALID;
    assign req_wr0 = m0_AWVALID | m0_WVALID;
    assign req_wr1 = m1_AWVALID | m1_WVALID;
    assign any0    = req_rd0 | req_wr0;
    assign any1    = req_rd1 | req_wr1;

    // Sole requester wins; on contention the master not served last wins.
    assign winner    = (any0 & any1) ? ~last : any1;
    assign winner_rd = winner ? req_rd1 : req_rd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any0 | any1) begin
                        owner <= winner;
                        state <= winner_rd ? S_READ : S_WRITE;
                    end
                end
                S_READ: begin
                    if (s_RVALID & s_RREADY) begin
                        state <= S_IDLE;
                        last  <= owner;
                    end
                end
                S_WRITE: begin
                    if (s_BVALID & s_BREADY) begin
                        state <= S_IDLE;
                        last  <= owner;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rd_gnt = (state == S_READ);
    assign wr_gnt = (state == S_WRITE);
    assign busy   = (state != S_IDLE);

    assign s_ARVALID = rd_gnt & (owner ? m1_ARVALID : m0_ARVALID);
    assign s_RREADY  = rd_gnt & (owner ? m1_RREADY  : m0_RREADY);
    assign s_AWVALID = wr_gnt & (owner ? m1_AWVALID : m0_AWVALID);
    assign s_WVALID  = wr_gnt & (owner ? m1_WVALID  : m0_WVALID);
    assign s_BREADY  = wr_gnt & (owner ? m1_BREADY  : m0_BREADY);

    assign s_ARADDR = owner ? m1_ARADDR : m0_ARADDR;
    assign s_AWADDR = owner ? m1_AWADDR : m0_AWADDR;
    assign s_WDATA  = owner ? m1_WDATA  : m0_WDATA;
    assign s_WSTRB  = owner ? m1_WSTRB  : m0_WSTRB;

    assign m0_ARREADY = rd_gnt & ~owner & s_ARREADY;
    assign m0_RVALID  = rd_gnt & ~owner & s_RVALID;
    assign m0_AWREADY = wr_gnt & ~owner & s_AWREADY;
    assign m0_WREADY  = wr_gnt & ~owner & s_WREADY;
    assign m0_BVALID  = wr_gnt & ~owner & s_BVALID;

    assign m1_ARREADY = rd_gnt & owner & s_ARREADY;
    assign m1_RVALID  = rd_gnt & owner & s_RVALID;
    assign m1_AWREADY = wr_gnt & owner & s_AWREADY;
    assign m1_WREADY  = wr_gnt & owner & s_WREADY;
    assign m1_BVALID  = wr_gnt & owner & s_BVALID;

    // Response payloads go to both masters; only the valids are steered.
    assign m0_RDATA = s_RDATA;
    assign m0_RRESP = s_RRESP;
    assign m0_BRESP = s_BRESP;
    assign m1_RDATA = s_RDATA;
    assign m1_RRESP = s_RRESP;
    assign m1_BRESP = s_BRESP;

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Scoreboard bench for axi4_lite_arbiter: two random masters, an SRAM-like slave
// model, a memory reference model and a decoupled response monitor.
module tb_axi4_lite_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] ar_addr [2];
    logic        ar_valid [2];
    logic        ar_ready [2];
    logic [31:0] r_data [2];
    logic [1:0]  r_resp [2];
    logic        r_valid [2];
    logic        r_ready [2];
    logic [31:0] aw_addr [2];
    logic        aw_valid [2];
    logic        aw_ready [2];
    logic [31:0] w_data [2];
    logic [3:0]  w_strb [2];
    logic        w_valid [2];
    logic        w_ready [2];
    logic [1:0]  b_resp [2];
    logic        b_valid [2];
    logic        b_ready [2];

    logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]  s_rresp, s_bresp;
    logic [3:0]  s_wstrb;
    logic        busy;

    axi4_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_ARADDR(ar_addr[0]), .m0_ARVALID(ar_valid[0]), .m0_ARREADY(ar_ready[0]),
        .m0_RDATA(r_data[0]), .m0_RRESP(r_resp[0]), .m0_RVALID(r_valid[0]), .m0_RREADY(r_ready[0]),
        .m0_AWADDR(aw_addr[0]), .m0_AWVALID(aw_valid[0]), .m0_AWREADY(aw_ready[0]),
        .m0_WDATA(w_data[0]), .m0_WSTRB(w_strb[0]), .m0_WVALID(w_valid[0]), .m0_WREADY(w_ready[0]),
        .m0_BRESP(b_resp[0]), .m0_BVALID(b_valid[0]), .m0_BREADY(b_ready[0]),
        .m1_ARADDR(ar_addr[1]), .m1_ARVALID(ar_valid[1]), .m1_ARREADY(ar_ready[1]),
        .m1_RDATA(r_data[1]), .m1_RRESP(r_resp[1]), .m1_RVALID(r_valid[1]), .m1_RREADY(r_ready[1]),
        .m1_AWADDR(aw_addr[1]), .m1_AWVALID(aw_valid[1]), .m1_AWREADY(aw_ready[1]),
        .m1_WDATA(w_data[1]), .m1_WSTRB(w_strb[1]), .m1_WVALID(w_valid[1]), .m1_WREADY(w_ready[1]),
        .m1_BRESP(b_resp[1]), .m1_BVALID(b_valid[1]), .m1_BREADY(b_ready[1]),
        .s_ARADDR(s_araddr), .s_ARVALID(s_arvalid), .s_ARREADY(s_arready),
        .s_RDATA(s_rdata), .s_RRESP(s_rresp), .s_RVALID(s_rvalid), .s_RREADY(s_rready),
        .s_AWADDR(s_awaddr), .s_AWVALID(s_awvalid), .s_AWREADY(s_awready),
        .s_WDATA(s_wdata), .s_WSTRB(s_wstrb), .s_WVALID(s_wvalid), .s_WREADY(s_wready),
        .s_BRESP(s_bresp), .s_BVALID(s_bvalid), .s_BREADY(s_bready),
        .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    rexp_t      exp_r [2][$];
    logic [1:0] exp_b [2][$];
    logic [1:0] glog [$];       // {master, kind: 0 read / 1 write} per completion
    int         comp_cyc [$];
    int         start_cyc [$];
    int         b_cnt [2];
    logic [31:0] last_rd [2];

    logic [31:0] ref_mem [bit [31:0]];
    logic [31:0] smem [bit [31:0]];
    bit          hold_b = 1'b0;
    logic [31:0] last_aw, last_wd;
    logic [3:0]  last_ws;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a ^ 32'hA5C3_0F17) * 32'h0001_0003 + 32'h0000_1357;
    endfunction

    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return (a[5:2] == 4'hF) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] sm_rd(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_masters();
        for (int n = 0; n < 2; n++) begin
            ar_valid[n] = 1'b0; aw_valid[n] = 1'b0; w_valid[n] = 1'b0;
            r_ready[n] = 1'b0;  b_ready[n] = 1'b0;
            ar_addr[n] = '0; aw_addr[n] = '0; w_data[n] = '0; w_strb[n] = '0;
        end
    endtask

    // Slave model: random ready, 0-2 cycle read latency, write done once AW and W both seen.
    initial begin
        logic [31:0] cap_ar, cap_aw, cap_wd, rd_addr, aw_q, wd_q;
        logic [3:0]  cap_ws, ws_q;
        bit hs_ar, hs_r, hs_aw, hs_w, hs_b, rd_pend, aw_got, w_got;
        int rd_wait;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
        rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; rd_wait = 0;
        rd_addr = '0; aw_q = '0; wd_q = '0; ws_q = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                s_arready = 1'b0; s_rvalid = 1'b0; s_awready = 1'b0;
                s_wready = 1'b0; s_bvalid = 1'b0;
                rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
                continue;
            end
            hs_ar = s_arvalid & s_arready; cap_ar = s_araddr;
            hs_r  = s_rvalid & s_rready;
            hs_aw = s_awvalid & s_awready; cap_aw = s_awaddr;
            hs_w  = s_wvalid & s_wready;   cap_wd = s_wdata; cap_ws = s_wstrb;
            hs_b  = s_bvalid & s_bready;
            @(posedge clk);
            #1;
            if (rst) continue;
            if (hs_r) s_rvalid = 1'b0;
            if (hs_ar) begin
                rd_pend = 1'b1; rd_addr = cap_ar; rd_wait = $urandom_range(0, 2);
            end
            if (rd_pend && !s_rvalid) begin
                if (rd_wait == 0) begin
                    s_rvalid = 1'b1; s_rdata = sm_rd(rd_addr); s_rresp = resp_of(rd_addr);
                    rd_pend = 1'b0;
                end else begin
                    rd_wait--;
                end
            end
            if (!s_rvalid) s_rdata = $urandom;
            s_arready = !rd_pend && !s_rvalid && ($urandom_range(0, 3) != 0);
            if (hs_b) begin
                s_bvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0;
            end
            if (hs_aw) begin aw_got = 1'b1; aw_q = cap_aw; last_aw = cap_aw; end
            if (hs_w) begin
                w_got = 1'b1; wd_q = cap_wd; ws_q = cap_ws; last_wd = cap_wd; last_ws = cap_ws;
            end
            if (aw_got && w_got && !s_bvalid && !hold_b) begin
                smem[aw_q] = merge(sm_rd(aw_q), wd_q, ws_q);
                s_bvalid = 1'b1; s_bresp = resp_of(aw_q);
            end
            s_awready = !aw_got && ($urandom_range(0, 3) != 0);
            s_wready  = !w_got && ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expectations on every master-side R/B handshake, checks exclusivity.
    initial begin
        rexp_t e;
        bit prev_busy;
        prev_busy = 1'b0;
        b_cnt[0] = 0; b_cnt[1] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin prev_busy = 1'b0; continue; end
            for (int n = 0; n < 2; n++) begin
                if (r_valid[n] && r_ready[n]) begin
                    if (exp_r[n].size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_r m%0d: got RVALID, required no response", n);
                    end else begin
                        e = exp_r[n].pop_front();
                        chk($sformatf("r_data_m%0d", n), r_data[n], e.data);
                        chk($sformatf("r_resp_m%0d", n), {30'd0, r_resp[n]}, {30'd0, e.resp});
                    end
                    last_rd[n] = r_data[n];
                    glog.push_back({n[0], 1'b0});
                    comp_cyc.push_back(cyc);
                end
                if (b_valid[n] && b_ready[n]) begin
                    if (exp_b[n].size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_b m%0d: got BVALID, required no response", n);
                    end else begin
                        chk($sformatf("b_resp_m%0d", n), {30'd0, b_resp[n]},
                            {30'd0, exp_b[n].pop_front()});
                    end
                    b_cnt[n]++;
                    glog.push_back({n[0], 1'b1});
                    comp_cyc.push_back(cyc);
                end
            end
            if (busy && !prev_busy) start_cyc.push_back(cyc);
            prev_busy = busy;
            chk("rvalid_onehot", {31'd0, r_valid[0] & r_valid[1]}, 32'd0);
            chk("rvalid_mirror", {31'd0, r_valid[0] | r_valid[1]}, {31'd0, s_rvalid});
            chk("bvalid_mirror", {31'd0, b_valid[0] | b_valid[1]}, {31'd0, s_bvalid});
            chk("rd_wr_exclusive", {31'd0, (s_arvalid | s_rready) & (s_awvalid | s_wvalid | s_bready)}, 32'd0);
            if (!busy)
                chk("idle_quiet", {20'd0, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                    ar_ready[0], ar_ready[1], aw_ready[0], aw_ready[1], w_ready[0], w_ready[1],
                    r_valid[0] | b_valid[0] | r_valid[1] | b_valid[1]}, 32'd0);
        end
    end

    // One master transaction; called and returns at posedge+1.
    task automatic master_txn(input int n, input bit do_rd, input bit do_wr,
                              input logic [31:0] raddr, input logic [31:0] waddr,
                              input logic [31:0] wdata, input logic [3:0] wstrb, input int wdly);
        bit rd_r, wr_w, wr_b, h_ar, h_r, h_aw, h_w, h_b;
        int budget;
        rd_r = !do_rd; wr_w = !do_wr; wr_b = !do_wr;
        if (do_rd) begin
            exp_r[n].push_back({ref_rd(raddr), resp_of(raddr)});
            ar_addr[n] = raddr; ar_valid[n] = 1'b1;
        end
        if (do_wr) begin
            exp_b[n].push_back(resp_of(waddr));
            ref_mem[waddr] = merge(ref_rd(waddr), wdata, wstrb);
            aw_addr[n] = waddr; aw_valid[n] = 1'b1;
            w_data[n] = wdata; w_strb[n] = wstrb; w_valid[n] = (wdly == 0);
        end
        r_ready[n] = ($urandom_range(0, 3) != 0);
        b_ready[n] = ($urandom_range(0, 3) != 0);
        budget = 300;
        while (!(rd_r && wr_b)) begin
            @(negedge clk);
            h_ar = ar_valid[n] && ar_ready[n];
            h_r  = r_valid[n] && r_ready[n];
            h_aw = aw_valid[n] && aw_ready[n];
            h_w  = w_valid[n] && w_ready[n];
            h_b  = b_valid[n] && b_ready[n];
            @(posedge clk);
            #1;
            if (h_ar) ar_valid[n] = 1'b0;
            if (h_r)  rd_r = 1'b1;
            if (h_aw) aw_valid[n] = 1'b0;
            if (h_w) begin w_valid[n] = 1'b0; wr_w = 1'b1; end
            if (h_b)  wr_b = 1'b1;
            if (do_wr && !wr_w && !w_valid[n]) begin
                if (wdly <= 1) w_valid[n] = 1'b1;
                else wdly--;
            end
            r_ready[n] = ($urandom_range(0, 3) != 0);
            b_ready[n] = ($urandom_range(0, 3) != 0);
            budget--;
            if (budget == 0) begin
                n_cmp++; n_err++;
                $display("FAIL timeout_m%0d: transaction incomplete, required completion within 300 cycles", n);
                ar_valid[n] = 1'b0; aw_valid[n] = 1'b0; w_valid[n] = 1'b0;
                break;
            end
        end
        r_ready[n] = 1'b0;
        b_ready[n] = 1'b0;
    endtask

    task automatic rand_txn(input int n, input bit gaps);
        logic [31:0] a, d;
        logic [3:0]  s;
        bit wr;
        int g;
        a  = (n == 1 ? 32'h8000_0100 : 32'h8000_0000) + (32'($urandom_range(0, 15)) << 2);
        d  = $urandom;
        s  = 4'($urandom_range(1, 15));
        wr = ($urandom_range(0, 1) == 1);
        if (gaps) begin
            g = $urandom_range(0, 3);
            repeat (g) begin @(posedge clk); #1; end
        end
        master_txn(n, !wr, wr, a, a, d, s, gaps ? $urandom_range(0, 2) : 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_masters();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation still running, required completion");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] iw;
        int b_before;
        bit got;
        clear_masters();
        // Requests held during reset must not leak through.
        ar_valid[0] = 1'b1; aw_valid[1] = 1'b1; w_valid[1] = 1'b1;
        r_ready[0] = 1'b1; b_ready[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_s_valids", {29'd0, s_arvalid, s_awvalid, s_wvalid}, 32'd0);
        chk("rst_s_readies", {30'd0, s_rready, s_bready}, 32'd0);
        chk("rst_m_readies", {26'd0, ar_ready[0], ar_ready[1], aw_ready[0], aw_ready[1],
            w_ready[0], w_ready[1]}, 32'd0);
        chk("rst_m_valids", {28'd0, r_valid[0], r_valid[1], b_valid[0], b_valid[1]}, 32'd0);
        clear_masters();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single M0 read: one cycle of arbitration latency.
        fork
            master_txn(0, 1'b1, 1'b0, 32'h8000_0000, '0, '0, '0, 0);
            begin
                @(negedge clk);
                chk("b_pre_s_arvalid", {31'd0, s_arvalid}, 32'd0);
                chk("b_pre_busy", {31'd0, busy}, 32'd0);
                @(negedge clk);
                chk("b_s_arvalid", {31'd0, s_arvalid}, 32'd1);
                chk("b_busy", {31'd0, busy}, 32'd1);
                chk("b_s_araddr", s_araddr, 32'h8000_0000);
                chk("b_m1_quiet", {27'd0, ar_ready[1], r_valid[1], aw_ready[1], w_ready[1],
                    b_valid[1]}, 32'd0);
            end
        join

        // M1 partial-strobe write, then read back.
        b_before = b_cnt[1];
        master_txn(1, 1'b0, 1'b1, '0, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0011, 1);
        chk("c_s_awaddr", last_aw, 32'h8000_0010);
        chk("c_s_wdata", last_wd, 32'hDEAD_BEEF);
        chk("c_s_wstrb", {28'd0, last_ws}, 32'd3);
        chk("c_bvalid_once", b_cnt[1] - b_before, 32'd1);
        master_txn(1, 1'b1, 1'b0, 32'h8000_0010, '0, '0, '0, 0);
        iw = init_word(32'h8000_0010);
        chk("c_read_low_half", last_rd[1], {iw[31:16], 16'hBEEF});

        // Continuous contention from reset: grants must alternate starting with M0.
        do_reset();
        glog.delete(); comp_cyc.delete(); start_cyc.delete();
        fork
            for (int k = 0; k < 5; k++) rand_txn(0, 1'b0);
            for (int k = 0; k < 5; k++) rand_txn(1, 1'b0);
        join
        chk("d_grant_count", glog.size(), 32'd10);
        chk("d_start_count", start_cyc.size(), 32'd10);
        for (int i = 0; i < glog.size(); i++)
            chk($sformatf("d_grant_%0d", i), {31'd0, glog[i][1]}, 32'(i % 2));
        for (int i = 0; i + 1 < start_cyc.size() && i < comp_cyc.size(); i++)
            chk($sformatf("d_idle_gap_%0d", i), start_cyc[i+1] - comp_cyc[i], 32'd2);

        // Random traffic from both masters with gaps and split AW/W.
        fork
            for (int k = 0; k < 15; k++) rand_txn(0, 1'b1);
            for (int k = 0; k < 15; k++) rand_txn(1, 1'b1);
        join

        // Reset in the middle of an M1 write whose B is held back.
        hold_b = 1'b1;
        aw_addr[1] = 32'h8000_0120; aw_valid[1] = 1'b1;
        w_data[1] = 32'h1234_5678; w_strb[1] = 4'hF; w_valid[1] = 1'b1; b_ready[1] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_awvalid && s_awready) begin got = 1'b1; break; end
        end
        chk("e_aw_accepted", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1 aw_valid[1] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("e_busy_before", {31'd0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("e_busy", {31'd0, busy}, 32'd0);
        chk("e_s_awvalid", {31'd0, s_awvalid}, 32'd0);
        chk("e_s_wvalid", {31'd0, s_wvalid}, 32'd0);
        chk("e_m1_bvalid", {31'd0, b_valid[1]}, 32'd0);
        clear_masters();
        hold_b = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        master_txn(0, 1'b1, 1'b0, 32'h8000_0008, '0, '0, '0, 0);

        // M0 read+write together with last=0: read first, one idle cycle, then write.
        glog.delete(); comp_cyc.delete(); start_cyc.delete();
        master_txn(0, 1'b1, 1'b1, 32'h8000_0004, 32'h8000_0024, 32'hCAFE_F00D, 4'hF, 0);
        chk("f_count", glog.size(), 32'd2);
        if (glog.size() == 2) begin
            chk("f_first_read", {30'd0, glog[0]}, 32'd0);
            chk("f_then_write", {30'd0, glog[1]}, 32'd1);
        end
        if (start_cyc.size() == 2 && comp_cyc.size() == 2)
            chk("f_idle_gap", start_cyc[1] - comp_cyc[0], 32'd2);

        repeat (5) @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("end_exp_r%0d_empty", n), exp_r[n].size(), 32'd0);
            chk($sformatf("end_exp_b%0d_empty", n), exp_b[n].size(), 32'd0);
        end
        summary();
        $finish;
    end

endmodule
